// File: rtl/bin_bcd_seg_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with registered 7-segment outputs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bin_bcd_seg_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              r_state, w_state_next;
  logic [WIDTH-1:0]    r_bin;
  logic [AW-1:0]       r_acc;
  logic                r_ovf;
  logic [CW-1:0]       r_count;
  logic                r_busy, r_done, r_ovf_out;
  logic [AW-1:0]       r_bcd;
  logic [7*DIGITS-1:0] r_seg;

  logic [AW-1:0]       w_acc_adj, w_acc_shift;
  logic                w_shout, w_ovf_final, w_last;
  logic [7*DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction per digit (no inter-digit carry), then shift {acc, bin} left by one.
  always_comb begin
    w_acc_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      else                         w_acc_adj[4*d +: 4] = r_acc[4*d +: 4];
    end
  end

  assign w_acc_shift = {w_acc_adj[AW-2:0], r_bin[WIDTH-1]};
  assign w_shout     = w_acc_adj[AW-1];
  assign w_ovf_final = r_ovf | w_shout;

  always_comb begin : p_seg
    logic       w_lead;
    logic [3:0] w_nib;
    w_seg_next = '1;
    w_lead     = 1'b1;
    w_nib      = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_nib = w_acc_shift[4*d +: 4];
      if (w_ovf_final) begin
        w_seg_next[7*d +: 7] = 7'b0111111;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (w_lead && (w_nib == 4'd0) && (d != 0)) w_seg_next[7*d +: 7] = 7'b1111111;
        else                                       w_seg_next[7*d +: 7] = seg7(w_nib);
`else
        w_seg_next[7*d +: 7] = seg7(w_nib);
`endif
      end
      if (w_nib != 4'd0) w_lead = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin     <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf_out <= 1'b0;
      r_bcd     <= '0;
      r_seg     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_shift;
          r_bin   <= r_bin << 1;
          r_ovf   <= w_ovf_final;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_bcd     <= w_acc_shift;
            r_seg     <= w_seg_next;
            r_ovf_out <= w_ovf_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf_out;
  assign bcd  = r_bcd;
  assign seg  = r_seg;

endmodule

// File: tb/tb_bin_bcd_seg_conv.sv
// Directed bench for bin_bcd_seg_conv: three instances (8b/3 digits, 8b/2 digits, 1b/1 digit).
module tb_bin_bcd_seg_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: WIDTH=8, DIGITS=3
  logic        a_start = 1'b0;
  logic [7:0]  a_bin   = '0;
  logic        a_busy, a_done, a_ovf;
  logic [11:0] a_bcd;
  logic [20:0] a_seg;

  // Instance B: WIDTH=8, DIGITS=2
  logic        b_start = 1'b0;
  logic [7:0]  b_bin   = '0;
  logic        b_busy, b_done, b_ovf;
  logic [7:0]  b_bcd;
  logic [13:0] b_seg;

  // Instance C: WIDTH=1, DIGITS=1
  logic        c_start = 1'b0;
  logic [0:0]  c_bin   = '0;
  logic        c_busy, c_done, c_ovf;
  logic [3:0]  c_bcd;
  logic [6:0]  c_seg;

  bin_bcd_seg_conv #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .bin(a_bin),
    .busy(a_busy), .done(a_done), .ovf(a_ovf), .bcd(a_bcd), .seg(a_seg));

  bin_bcd_seg_conv #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .bin(b_bin),
    .busy(b_busy), .done(b_done), .ovf(b_ovf), .bcd(b_bcd), .seg(b_seg));

  bin_bcd_seg_conv #(.WIDTH(1), .DIGITS(1)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .bin(c_bin),
    .busy(c_busy), .done(c_done), .ovf(c_ovf), .bcd(c_bcd), .seg(c_seg));

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [20:0] SEG_0 = {SB, SB, S0};
  localparam logic [20:0] SEG_7 = {SB, SB, S7};
`else
  localparam logic [20:0] SEG_0 = {S0, S0, S0};
  localparam logic [20:0] SEG_7 = {S0, S0, S7};
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; start is seen by the next rising edge.
  task automatic a_go(input logic [7:0] v);
    a_start = 1'b1;
    a_bin   = v;
    @(negedge clk);
    a_start = 1'b0;
    a_bin   = 8'hA5;
  endtask

  // Returns the number of negedges since acceptance until done is seen, and busy-high count.
  task automatic a_wait(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (!a_done && lat < 40) begin
      if (a_busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic a_conv(input string tag, input logic [7:0] v, input logic [11:0] eb,
                        input logic [20:0] es, input logic eo);
    int lat, bc;
    a_go(v);
    a_wait(1, lat, bc);
    check({tag, "_lat"},  lat, 9);
    check({tag, "_busy"}, bc, 8);
    check({tag, "_done"}, a_done, 1'b1);
    check({tag, "_bcd"},  a_bcd, eb);
    check({tag, "_seg"},  a_seg, es);
    check({tag, "_ovf"},  a_ovf, eo);
    @(negedge clk);
    check({tag, "_pulse"}, a_done, 1'b0);
    check({tag, "_hold"},  a_bcd, eb);
  endtask

  task automatic b_conv(input string tag, input logic [7:0] v, input logic [7:0] eb,
                        input logic [13:0] es, input logic eo);
    int lat;
    b_start = 1'b1;
    b_bin   = v;
    @(negedge clk);
    b_start = 1'b0;
    lat = 1;
    while (!b_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_bcd"}, b_bcd, eb);
    check({tag, "_seg"}, b_seg, es);
    check({tag, "_ovf"}, b_ovf, eo);
    @(negedge clk);
  endtask

  task automatic c_conv(input string tag, input logic v, input logic [3:0] eb, input logic [6:0] es);
    int lat;
    c_start = 1'b1;
    c_bin   = v;
    @(negedge clk);
    c_start = 1'b0;
    lat = 1;
    while (!c_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_bcd"}, c_bcd, eb);
    check({tag, "_seg"}, c_seg, es);
    check({tag, "_ovf"}, c_ovf, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc, dn;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_ovf",  a_ovf, 1'b0);
    check("rst_bcd",  a_bcd, 12'h000);
    check("rst_seg",  a_seg, {SB, SB, SB});
    check("rst_seg_c", c_seg, SB);

    a_conv("a255", 8'd255, 12'h255, {S2, S5, S5}, 1'b0);
    a_conv("a0",   8'd0,   12'h000, SEG_0, 1'b0);
    a_conv("a7",   8'd7,   12'h007, SEG_7, 1'b0);

    // Second start while busy is ignored; start held in the done cycle is accepted.
    a_go(8'd42);
    @(negedge clk);
    a_start = 1'b1;
    a_bin   = 8'd200;
    @(negedge clk);
    a_start = 1'b0;
    check("hs_busy", a_busy, 1'b1);
    a_wait(3, lat, bc);
    check("hs_lat", lat, 9);
    check("hs_bcd42", a_bcd, 12'h042);
    a_go(8'd13);
    check("hs_busy2", a_busy, 1'b1);
    check("hs_done2", a_done, 1'b0);
    a_wait(1, lat, bc);
    check("hs_lat2", lat, 9);
    check("hs_bcd13", a_bcd, 12'h013);
    @(negedge clk);

    // Reset at edge k+4 aborts the conversion.
    a_go(8'd180);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", a_busy, 1'b0);
    check("mid_done", a_done, 1'b0);
    check("mid_ovf",  a_ovf, 1'b0);
    check("mid_bcd",  a_bcd, 12'h000);
    check("mid_seg",  a_seg, {SB, SB, SB});
    dn = 0;
    repeat (12) begin
      if (a_done) dn++;
      @(negedge clk);
    end
    check("mid_nodone", dn, 0);
    a_conv("a180", 8'd180, 12'h180, {S1, S8, S0}, 1'b0);

    b_conv("b100", 8'd100, 8'h00, {SD, SD}, 1'b1);
    b_conv("b99",  8'd99,  8'h99, {S9, S9}, 1'b0);
    b_conv("b255", 8'd255, 8'h55, {SD, SD}, 1'b1);

    c_conv("c1", 1'b1, 4'h1, S1);
    c_conv("c0", 1'b0, 4'h0, S0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
